mem_access_unit: RTL

//   Parametrised load/store sequencer between the multicycle datapath and the data memory.

---
 rtl/mem_access_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer between a multicycle datapath and a full-width data memory.
// Sub-word stores are read-modify-write; misaligned requests complete without touching memory.
module mem_access_unit #(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_misaligned,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic              mem_wr,
    input  logic [XLEN-1:0]   mem_rdata
);
    localparam int OFF_W = $clog2(XLEN / 8);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [1:0]       FULL_SIZE = (XLEN == 64) ? 2'd3 : 2'd2;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;
    state_t state, next_state;

    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              unsigned_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdbuf;

    logic              accept;
    logic              req_misaligned;
    logic              rd_last;
    logic [OFF_W+2:0]  sh;
    logic [XLEN-1:0]   size_mask;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   load_val;
    logic [XLEN-1:0]   store_mask;
    logic              sign_bit;

    assign accept  = req_valid && req_ready;
    assign rd_last = (wait_cnt == LAST_CNT);

    always_comb begin
        case (req_size)
            2'd0:    req_misaligned = 1'b0;
            2'd1:    req_misaligned = req_addr[0];
            2'd2:    req_misaligned = |req_addr[1:0];
            default: req_misaligned = (XLEN == 32) || (|req_addr[2:0]);
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RESET) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every always_comb output is given a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_misaligned)                          next_state = RESP;
                    else if (!req_we || req_size != FULL_SIZE)   next_state = RD_WAIT;
                    else                                         next_state = WRITE;
                end
            end
            RD_WAIT: if (rd_last) next_state = we_q ? WRITE : RESP;
            WRITE:   next_state = RESP;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) && RESET;
        rsp_valid = (state == RESP);
        mem_wr    = (state == WRITE) && RESET;
    end

    // Lane extraction and merge; the load value is taken from mem_rdata in the same
    // cycle it is captured into rdbuf, so the response register is ready on RESP entry.
    always_comb begin
        sh      = {addr_q[OFF_W-1:0], 3'b000};
        shifted = mem_rdata >> sh;
        case (size_q)
            2'd0:    begin size_mask = XLEN'(8'hFF);         sign_bit = shifted[7];      end
            2'd1:    begin size_mask = XLEN'(16'hFFFF);      sign_bit = shifted[15];     end
            2'd2:    begin size_mask = XLEN'(32'hFFFF_FFFF); sign_bit = shifted[31];     end
            default: begin size_mask = '1;                   sign_bit = shifted[XLEN-1]; end
        endcase
        load_val   = (shifted & size_mask) | ((sign_bit && !unsigned_q) ? ~size_mask : '0);
        store_mask = size_mask << sh;
        mem_wdata  = (size_q == FULL_SIZE) ? wdata_q
                   : (rdbuf & ~store_mask) | ((wdata_q << sh) & store_mask);
    end

    assign mem_raddr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_waddr = mem_raddr;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wait_cnt       <= '0;
            addr_q         <= '0;
            size_q         <= '0;
            we_q           <= 1'b0;
            unsigned_q     <= 1'b0;
            wdata_q        <= '0;
            rdbuf          <= '0;
            rsp_rdata      <= '0;
            rsp_misaligned <= 1'b0;
        end else begin
            wait_cnt <= (state == RD_WAIT && !rd_last) ? wait_cnt + 1'b1 : '0;
            if (accept) begin
                addr_q     <= req_addr;
                size_q     <= req_size;
                we_q       <= req_we;
                unsigned_q <= req_unsigned;
                wdata_q    <= req_wdata;
            end
            if (state == RD_WAIT && rd_last) rdbuf <= mem_rdata;
            // Only a misaligned accept jumps straight from IDLE to RESP; only loads leave RD_WAIT for RESP.
            if (state != RESP && next_state == RESP) begin
                rsp_misaligned <= (state == IDLE);
                rsp_rdata      <= (state == RD_WAIT) ? load_val : '0;
            end
        end
    end

endmodule
